// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control unit and its datapath.
// The multiply/divide states exist only when CU_MULTDIV_EN is defined.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    localparam logic [3:0] SRCD_ALUOUT  = 4'd0;
    localparam logic [3:0] SRCD_LS      = 4'd1;
    localparam logic [3:0] SRCD_HI      = 4'd2;
    localparam logic [3:0] SRCD_LO      = 4'd3;
    localparam logic [3:0] SRCD_LUI     = 4'd5;
    localparam logic [3:0] SRCD_SP_INIT = 4'd8;

    localparam logic [2:0] SRCW_RT = 3'd0;
    localparam logic [2:0] SRCW_RD = 3'd1;
    localparam logic [2:0] SRCW_SP = 3'd2;
    localparam logic [2:0] SRCW_RA = 3'd4;

    localparam logic [2:0] PCS_RESULT = 3'd0;
    localparam logic [2:0] PCS_ALUOUT = 3'd1;
    localparam logic [2:0] PCS_CONCAT = 3'd2;
    localparam logic [2:0] PCS_LS     = 3'd5;

    localparam logic [1:0] EXC_OPCODE   = 2'd0;
    localparam logic [1:0] EXC_OVERFLOW = 2'd1;
    localparam logic [1:0] EXC_DIVZERO  = 2'd2;

    localparam logic [1:0] IORD_PC     = 2'd0;
    localparam logic [1:0] IORD_ALUOUT = 2'd1;
    localparam logic [1:0] IORD_VECTOR = 2'd2;

    localparam logic [1:0] ALUA_PC   = 2'd0;
    localparam logic [1:0] ALUA_A    = 2'd1;
    localparam logic [1:0] ALUB_B    = 2'd0;
    localparam logic [1:0] ALUB_FOUR = 2'd1;
    localparam logic [1:0] ALUB_SEXT = 2'd2;
    localparam logic [1:0] ALUB_SHL2 = 2'd3;

    localparam logic [1:0] LS_WORD = 2'd0;
    localparam logic [1:0] LS_BYTE = 2'd2;

    typedef enum logic [5:0] {
        ST_RESET, ST_FETCH0, ST_FETCH_WAIT, ST_FETCH_LAST, ST_DECODE,
        ST_R_ADD, ST_R_SUB, ST_R_AND, ST_R_WB, ST_ADDI_ALU, ST_ADDI_WB,
        ST_LS_ADDR, ST_LW_READ, ST_LW_WAIT, ST_LW_WB, ST_SW_WRITE,
        ST_BR_TAKEN, ST_BR_NOT, ST_J, ST_JAL0, ST_JAL1, ST_JR, ST_LUI_WB,
`ifdef CU_MULTDIV_EN
        ST_MFHI_WB, ST_MFLO_WB, ST_MULT_START, ST_DIV_START, ST_MD_WAIT,
`endif
        ST_EXC0, ST_EXC1, ST_EXC_WAIT, ST_EXC_LAST
    } ctrlState_t;

    typedef struct packed {
        logic       pcWrite;
        logic       irWrite;
        logic       memWrite;
        logic       regWrite;
        logic       aluOutControl;
        logic       epcControl;
        logic       multControl;
        logic       divControl;
        logic [1:0] iord;
        logic [1:0] excpControl;
        logic [2:0] srcWrite;
        logic [3:0] srcData;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluControl;
        logic [1:0] lsControl;
        logic [2:0] pcSource;
    } ctrlWord_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// State to control-word table for the MIPS control unit; purely combinational.
// MD states are decoded only when CU_MULTDIV_EN is defined.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  ctrlState_t state,
    input  logic [1:0] excCode,
    output ctrlWord_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_RESET: begin
                ctrl.regWrite = 1'b1;
                ctrl.srcWrite = SRCW_SP;
                ctrl.srcData  = SRCD_SP_INIT;
            end
            ST_FETCH0, ST_FETCH_WAIT, ST_FETCH_LAST: begin
                ctrl.iord       = IORD_PC;
                ctrl.aluSrcA    = ALUA_PC;
                ctrl.aluSrcB    = ALUB_FOUR;
                ctrl.aluControl = ALU_ADD;
                ctrl.pcSource   = PCS_RESULT;
                ctrl.irWrite    = (state == ST_FETCH_LAST);
                ctrl.pcWrite    = (state == ST_FETCH_LAST);
            end
            ST_DECODE: begin
                ctrl.aluSrcA       = ALUA_PC;
                ctrl.aluSrcB       = ALUB_SHL2;
                ctrl.aluControl    = ALU_ADD;
                ctrl.aluOutControl = 1'b1;
            end
            ST_R_ADD, ST_R_SUB, ST_R_AND: begin
                ctrl.aluSrcA       = ALUA_A;
                ctrl.aluSrcB       = ALUB_B;
                ctrl.aluOutControl = 1'b1;
                ctrl.aluControl    = (state == ST_R_SUB) ? ALU_SUB :
                                     (state == ST_R_AND) ? ALU_AND : ALU_ADD;
            end
            ST_R_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.srcWrite = SRCW_RD;
                ctrl.srcData  = SRCD_ALUOUT;
            end
            ST_ADDI_ALU, ST_LS_ADDR: begin
                ctrl.aluSrcA       = ALUA_A;
                ctrl.aluSrcB       = ALUB_SEXT;
                ctrl.aluControl    = ALU_ADD;
                ctrl.aluOutControl = 1'b1;
            end
            ST_ADDI_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.srcWrite = SRCW_RT;
                ctrl.srcData  = SRCD_ALUOUT;
            end
            ST_LW_READ, ST_LW_WAIT: begin
                ctrl.iord      = IORD_ALUOUT;
                ctrl.lsControl = LS_WORD;
            end
            ST_LW_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.srcWrite  = SRCW_RT;
                ctrl.srcData   = SRCD_LS;
                ctrl.lsControl = LS_WORD;
            end
            ST_SW_WRITE: begin
                ctrl.iord      = IORD_ALUOUT;
                ctrl.memWrite  = 1'b1;
                ctrl.lsControl = LS_WORD;
            end
            ST_BR_TAKEN, ST_BR_NOT: begin
                ctrl.aluSrcA    = ALUA_A;
                ctrl.aluSrcB    = ALUB_B;
                ctrl.aluControl = ALU_CMP;
                ctrl.pcSource   = PCS_ALUOUT;
                ctrl.pcWrite    = (state == ST_BR_TAKEN);
            end
            ST_J: begin
                ctrl.pcSource = PCS_CONCAT;
                ctrl.pcWrite  = 1'b1;
            end
            ST_JAL0: begin
                ctrl.aluSrcA       = ALUA_PC;
                ctrl.aluControl    = ALU_PASS;
                ctrl.aluOutControl = 1'b1;
            end
            ST_JAL1: begin
                ctrl.regWrite = 1'b1;
                ctrl.srcWrite = SRCW_RA;
                ctrl.srcData  = SRCD_ALUOUT;
                ctrl.pcSource = PCS_CONCAT;
                ctrl.pcWrite  = 1'b1;
            end
            ST_JR: begin
                ctrl.aluSrcA    = ALUA_A;
                ctrl.aluControl = ALU_PASS;
                ctrl.pcSource   = PCS_RESULT;
                ctrl.pcWrite    = 1'b1;
            end
            ST_LUI_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.srcWrite = SRCW_RT;
                ctrl.srcData  = SRCD_LUI;
            end
`ifdef CU_MULTDIV_EN
            ST_MFHI_WB, ST_MFLO_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.srcWrite = SRCW_RD;
                ctrl.srcData  = (state == ST_MFHI_WB) ? SRCD_HI : SRCD_LO;
            end
            ST_MULT_START: ctrl.multControl = 1'b1;
            ST_DIV_START:  ctrl.divControl  = 1'b1;
`endif
            ST_EXC0: begin
                ctrl.aluSrcA    = ALUA_PC;
                ctrl.aluSrcB    = ALUB_FOUR;
                ctrl.aluControl = ALU_SUB;
                ctrl.epcControl = 1'b1;
            end
            ST_EXC1, ST_EXC_WAIT, ST_EXC_LAST: begin
                ctrl.iord        = IORD_VECTOR;
                ctrl.excpControl = excCode;
                ctrl.lsControl   = (state == ST_EXC_LAST) ? LS_BYTE : LS_WORD;
                ctrl.pcSource    = (state == ST_EXC_LAST) ? PCS_LS : PCS_RESULT;
                ctrl.pcWrite     = (state == ST_EXC_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// Multicycle MIPS control FSM: next-state logic, exception-code latch and wait counter.
// Define CU_MULTDIV_EN to decode mult, div, mfhi and mflo.
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int FETCH_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       eq,
    input  logic       gt,
    input  logic       lt,
    input  logic       o,
    input  logic       md_done,
    input  logic       div_zero,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic       aluOutControl,
    output logic       epcControl,
    output logic       multControl,
    output logic       divControl,
    output logic [1:0] iord,
    output logic [1:0] excpControl,
    output logic [2:0] srcWrite,
    output logic [3:0] srcData,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [1:0] lsControl,
    output logic [2:0] pcSource
);

    // state          | meaning
    // RESET          | SP <- 227
    // FETCH0..LAST   | IR <- mem[PC], PC <- PC+4 after FETCH_WAIT wait states
    // DECODE         | ALUOut <- branch target; branch on class, eq and div_zero
    // R_*/ADDI_*     | ALU op (o sampled here), then register write-back
    // LS_ADDR/LW/SW  | address calc, read with wait states or write
    // BR_TAKEN/NOT   | compare A,B; PC <- ALUOut only in TAKEN
    // J/JAL0-1/JR    | jumps, JAL writes PC to r31
    // MFHI..MD_WAIT  | multiply/divide start and wait for md_done
    // EXC0..EXC_LAST | EPC <- PC-4, read vector, PC <- vector

    localparam int WCW = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'((FETCH_WAIT > 0) ? FETCH_WAIT - 1 : 0);

    ctrlState_t     state;
    logic [1:0]     excCode;
    logic [WCW-1:0] waitCnt;
    ctrlWord_t      ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RESET;
            excCode <= EXC_OPCODE;
            waitCnt <= '0;
        end else begin
            case (state)
                ST_RESET: state <= ST_FETCH0;
                ST_FETCH0: begin
                    waitCnt <= WAIT_LOAD;
                    state   <= (FETCH_WAIT > 0) ? ST_FETCH_WAIT : ST_FETCH_LAST;
                end
                ST_FETCH_WAIT: begin
                    if (waitCnt == '0) state <= ST_FETCH_LAST;
                    else               waitCnt <= waitCnt - 1'b1;
                end
                ST_FETCH_LAST: state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE: begin
                            case (funct)
                                FN_ADD: state <= ST_R_ADD;
                                FN_SUB: state <= ST_R_SUB;
                                FN_AND: state <= ST_R_AND;
                                FN_JR:  state <= ST_JR;
`ifdef CU_MULTDIV_EN
                                FN_MFHI: state <= ST_MFHI_WB;
                                FN_MFLO: state <= ST_MFLO_WB;
                                FN_MULT: state <= ST_MULT_START;
                                FN_DIV: begin
                                    if (div_zero) begin
                                        state   <= ST_EXC0;
                                        excCode <= EXC_DIVZERO;
                                    end else begin
                                        state   <= ST_DIV_START;
                                    end
                                end
`endif
                                default: begin
                                    state   <= ST_EXC0;
                                    excCode <= EXC_OPCODE;
                                end
                            endcase
                        end
                        OP_ADDI:      state <= ST_ADDI_ALU;
                        OP_LW, OP_SW: state <= ST_LS_ADDR;
                        // Branch outcome is captured into the state so pcWrite stays a state decode
                        OP_BEQ:       state <= eq ? ST_BR_TAKEN : ST_BR_NOT;
                        OP_BNE:       state <= eq ? ST_BR_NOT : ST_BR_TAKEN;
                        OP_J:         state <= ST_J;
                        OP_JAL:       state <= ST_JAL0;
                        OP_LUI:       state <= ST_LUI_WB;
                        default: begin
                            state   <= ST_EXC0;
                            excCode <= EXC_OPCODE;
                        end
                    endcase
                end
                ST_R_ADD, ST_R_SUB, ST_ADDI_ALU: begin
                    if (o) begin
                        state   <= ST_EXC0;
                        excCode <= EXC_OVERFLOW;
                    end else begin
                        state   <= (state == ST_ADDI_ALU) ? ST_ADDI_WB : ST_R_WB;
                    end
                end
                ST_R_AND:   state <= ST_R_WB;
                ST_LS_ADDR: state <= (opcode == OP_SW) ? ST_SW_WRITE : ST_LW_READ;
                ST_LW_READ: begin
                    waitCnt <= WAIT_LOAD;
                    state   <= (FETCH_WAIT > 0) ? ST_LW_WAIT : ST_LW_WB;
                end
                ST_LW_WAIT: begin
                    if (waitCnt == '0) state <= ST_LW_WB;
                    else               waitCnt <= waitCnt - 1'b1;
                end
                ST_JAL0: state <= ST_JAL1;
`ifdef CU_MULTDIV_EN
                ST_MULT_START, ST_DIV_START: state <= ST_MD_WAIT;
                ST_MD_WAIT: if (md_done) state <= ST_FETCH0;
`endif
                ST_EXC0: state <= ST_EXC1;
                ST_EXC1: begin
                    waitCnt <= WAIT_LOAD;
                    state   <= (FETCH_WAIT > 0) ? ST_EXC_WAIT : ST_EXC_LAST;
                end
                ST_EXC_WAIT: begin
                    if (waitCnt == '0) state <= ST_EXC_LAST;
                    else               waitCnt <= waitCnt - 1'b1;
                end
                default: state <= ST_FETCH0;
            endcase
        end
    end

    mips_ctrl_decode uDecode (
        .state   (state),
        .excCode (excCode),
        .ctrl    (ctrl)
    );

    assign pcWrite       = ctrl.pcWrite;
    assign irWrite       = ctrl.irWrite;
    assign memWrite      = ctrl.memWrite;
    assign regWrite      = ctrl.regWrite;
    assign aluOutControl = ctrl.aluOutControl;
    assign epcControl    = ctrl.epcControl;
    assign iord          = ctrl.iord;
    assign excpControl   = ctrl.excpControl;
    assign srcWrite      = ctrl.srcWrite;
    assign srcData       = ctrl.srcData;
    assign aluSrcA       = ctrl.aluSrcA;
    assign aluSrcB       = ctrl.aluSrcB;
    assign aluControl    = ctrl.aluControl;
    assign lsControl     = ctrl.lsControl;
    assign pcSource      = ctrl.pcSource;

    logic unusedInputs;
`ifdef CU_MULTDIV_EN
    assign multControl  = ctrl.multControl;
    assign divControl   = ctrl.divControl;
    assign unusedInputs = ^{zero, gt, lt};
`else
    assign multControl  = 1'b0;
    assign divControl   = 1'b0;
    assign unusedInputs = ^{zero, gt, lt, md_done, div_zero, ctrl.multControl, ctrl.divControl};
`endif

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed self-checking bench for mips_control_unit (FETCH_WAIT = 1).
// Multiply/divide expectations follow whether CU_MULTDIV_EN is defined.
module tb_mips_control_unit;

    logic       clk, reset;
    logic [5:0] opcode, funct;
    logic       zero, eq, gt, lt, o, md_done, div_zero;
    logic       pcWrite, irWrite, memWrite, regWrite, aluOutControl, epcControl;
    logic       multControl, divControl;
    logic [1:0] iord, excpControl, aluSrcA, aluSrcB, lsControl;
    logic [2:0] srcWrite, aluControl, pcSource;
    logic [3:0] srcData;

    int vectors = 0;
    int miscompares = 0;

    mips_control_unit #(.FETCH_WAIT(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .eq(eq), .gt(gt), .lt(lt), .o(o),
        .md_done(md_done), .div_zero(div_zero),
        .pcWrite(pcWrite), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
        .aluOutControl(aluOutControl), .epcControl(epcControl),
        .multControl(multControl), .divControl(divControl),
        .iord(iord), .excpControl(excpControl), .srcWrite(srcWrite), .srcData(srcData),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
        .lsControl(lsControl), .pcSource(pcSource)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with FETCH0 visible; leaves with DECODE visible.
    task automatic fetchDecode(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        check("fetch0.iord", iord, 0);
        check("fetch0.aluSrcB", aluSrcB, 1);
        tick();
        check("fetchWait.irWrite", irWrite, 0);
        tick();
        check("fetchLast.irWrite", irWrite, 1);
        check("fetchLast.pcWrite", pcWrite, 1);
        tick();
        check("decode.aluSrcB", aluSrcB, 3);
        check("decode.aluOutControl", aluOutControl, 1);
    endtask

    // Entered in the state just before EXC0; leaves with FETCH0 visible.
    task automatic excSeq(input logic [1:0] code);
        tick();
        check("exc0.epcControl", epcControl, 1);
        check("exc0.regWrite", regWrite, 0);
        check("exc0.aluControl", aluControl, 2);
        check("exc0.startPulses", {multControl, divControl}, 0);
        tick();
        check("exc1.iord", iord, 2);
        check("exc1.excpControl", excpControl, code);
        tick();
        check("excWait.pcWrite", pcWrite, 0);
        tick();
        check("excLast.lsControl", lsControl, 2);
        check("excLast.pcSource", pcSource, 5);
        check("excLast.pcWrite", pcWrite, 1);
        tick();
        check("excDone.fetch0", aluSrcB, 1);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0;
        zero = 0; eq = 0; gt = 0; lt = 0; o = 0; md_done = 0; div_zero = 0;

        repeat (3) tick();
        check("rst.regWrite", regWrite, 1);
        check("rst.srcWrite", srcWrite, 2);
        check("rst.srcData", srcData, 8);
        check("rst.pcWrite", pcWrite, 0);
        check("rst.excpControl", excpControl, 0);
        reset = 1'b0;
        #1;
        check("rstRelease.regWrite", regWrite, 1);
        tick();

        // add, no overflow
        fetchDecode(6'h00, 6'h20);
        tick();
        check("add.aluControl", aluControl, 1);
        check("add.aluSrcA", aluSrcA, 1);
        check("add.regWrite", regWrite, 0);
        tick();
        check("addWb.regWrite", regWrite, 1);
        check("addWb.srcWrite", srcWrite, 1);
        check("addWb.srcData", srcData, 0);
        tick();

        // add with overflow traps with code 1
        o = 1'b1;
        fetchDecode(6'h00, 6'h20);
        tick();
        excSeq(2'd1);
        o = 1'b0;

        // and ignores overflow
        o = 1'b1;
        fetchDecode(6'h00, 6'h24);
        tick();
        check("and.aluControl", aluControl, 3);
        tick();
        check("andWb.regWrite", regWrite, 1);
        o = 1'b0;
        tick();

        // sub, no overflow
        fetchDecode(6'h00, 6'h22);
        tick();
        check("sub.aluControl", aluControl, 2);
        tick();
        check("subWb.regWrite", regWrite, 1);
        tick();

        // illegal opcode
        fetchDecode(6'h3F, 6'h00);
        excSeq(2'd0);

        // beq / bne, eq held through decode and branch
        eq = 1'b0;
        fetchDecode(6'h04, 6'h00);
        tick();
        check("beqNot.pcWrite", pcWrite, 0);
        check("beqNot.aluControl", aluControl, 7);
        tick();
        eq = 1'b1;
        fetchDecode(6'h04, 6'h00);
        tick();
        check("beqTaken.pcWrite", pcWrite, 1);
        check("beqTaken.pcSource", pcSource, 1);
        tick();
        fetchDecode(6'h05, 6'h00);
        tick();
        check("bneEq.pcWrite", pcWrite, 0);
        tick();
        eq = 1'b0;
        fetchDecode(6'h05, 6'h00);
        tick();
        check("bneNe.pcWrite", pcWrite, 1);
        tick();

        // lw
        fetchDecode(6'h23, 6'h00);
        tick();
        check("lwAddr.aluSrcB", aluSrcB, 2);
        check("lwAddr.aluOutControl", aluOutControl, 1);
        tick();
        check("lwRead.iord", iord, 1);
        tick();
        check("lwWait.iord", iord, 1);
        check("lwWait.regWrite", regWrite, 0);
        tick();
        check("lwWb.regWrite", regWrite, 1);
        check("lwWb.srcData", srcData, 1);
        check("lwWb.srcWrite", srcWrite, 0);
        tick();
        check("lwDone.fetch0", aluSrcB, 1);

        // sw
        fetchDecode(6'h2B, 6'h00);
        tick();
        check("swAddr.aluSrcB", aluSrcB, 2);
        tick();
        check("swWrite.memWrite", memWrite, 1);
        check("swWrite.iord", iord, 1);
        tick();
        check("swDone.memWrite", memWrite, 0);

        // jal, j, jr, lui
        fetchDecode(6'h03, 6'h00);
        tick();
        check("jal0.aluOutControl", aluOutControl, 1);
        check("jal0.aluSrcA", aluSrcA, 0);
        check("jal0.aluControl", aluControl, 0);
        tick();
        check("jal1.regWrite", regWrite, 1);
        check("jal1.srcWrite", srcWrite, 4);
        check("jal1.pcSource", pcSource, 2);
        check("jal1.pcWrite", pcWrite, 1);
        tick();
        fetchDecode(6'h02, 6'h00);
        tick();
        check("j.pcSource", pcSource, 2);
        check("j.pcWrite", pcWrite, 1);
        tick();
        fetchDecode(6'h00, 6'h08);
        tick();
        check("jr.pcSource", pcSource, 0);
        check("jr.aluSrcA", aluSrcA, 1);
        check("jr.pcWrite", pcWrite, 1);
        tick();
        fetchDecode(6'h0F, 6'h00);
        tick();
        check("lui.srcData", srcData, 5);
        check("lui.regWrite", regWrite, 1);
        tick();

        // addi with and without overflow
        o = 1'b1;
        fetchDecode(6'h08, 6'h00);
        tick();
        check("addiOvf.aluSrcB", aluSrcB, 2);
        excSeq(2'd1);
        o = 1'b0;
        fetchDecode(6'h08, 6'h00);
        tick();
        tick();
        check("addiWb.regWrite", regWrite, 1);
        check("addiWb.srcWrite", srcWrite, 0);
        tick();

`ifdef CU_MULTDIV_EN
        div_zero = 1'b1;
        fetchDecode(6'h00, 6'h1A);
        check("divZero.divControl", divControl, 0);
        excSeq(2'd2);
        div_zero = 1'b0;

        fetchDecode(6'h00, 6'h1A);
        tick();
        check("divStart.divControl", divControl, 1);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        check("mdWait.divControl", divControl, 0);
        check("mdWait.early", aluSrcB, 0);
        repeat (31) tick();
        check("mdWait.held", aluSrcB, 0);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        check("divDone.fetch0", aluSrcB, 1);

        fetchDecode(6'h00, 6'h18);
        tick();
        check("multStart.multControl", multControl, 1);
        tick();
        check("multWait.multControl", multControl, 0);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        check("multDone.fetch0", aluSrcB, 1);

        fetchDecode(6'h00, 6'h10);
        tick();
        check("mfhi.srcData", srcData, 2);
        check("mfhi.regWrite", regWrite, 1);
        tick();
        fetchDecode(6'h00, 6'h12);
        tick();
        check("mflo.srcData", srcData, 3);
        tick();
`else
        fetchDecode(6'h00, 6'h18);
        check("multTrap.multControl", multControl, 0);
        excSeq(2'd0);
        div_zero = 1'b1;
        fetchDecode(6'h00, 6'h1A);
        excSeq(2'd0);
        div_zero = 1'b0;
`endif

        // reset in the middle of an exception sequence aborts at once
        o = 1'b1;
        fetchDecode(6'h00, 6'h22);
        tick();
        tick();
        tick();
        check("preRst.excpControl", excpControl, 1);
        o = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midRst.excpControl", excpControl, 0);
        check("midRst.iord", iord, 0);
        check("midRst.srcWrite", srcWrite, 2);
        tick();
        reset = 1'b0;
        #1;
        check("midRst.regWrite", regWrite, 1);
        tick();
        check("postRst.fetch0", aluSrcB, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
